// File: rtl/fib_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_gen
// Brief    : Fibonacci term generator, advanced by a prescaler or debounced steps.
// Revision : 1.0 - initial release
// ============================================================================
module fib_seq_gen #(
    parameter int WIDTH    = 32,
    parameter int LED_W    = 8,
    parameter int PRESCALE = 50000000,
    parameter int DEBOUNCE = 1000000,
    parameter int SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       buttons,
    input  logic             clr,
    input  logic             halt_on_ovf,
    input  logic [SEL_W-1:0] led_sel,
    output logic [LED_W-1:0] led,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             ovf,
    output logic             adv
);

    localparam int              c_DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);
    localparam int              c_PS_W    = $clog2(PRESCALE);
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam int              c_NSLICE  = 2 ** SEL_W;
    localparam int              c_PAD_W   = LED_W * c_NSLICE;

    logic [1:0]        w_press;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_bc;
    logic              r_running;
    logic              r_ovf;
    logic              r_adv;
    logic [c_PS_W-1:0] r_ps;
    logic [WIDTH:0]    w_sum;
    logic              w_tick;
    logic              w_req;

    // Per button: two-flop synchroniser, stability counter, rising-edge event.
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic              r_s1;
        logic              r_s2;
        logic              r_db;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= buttons[i];
                r_s2 <= r_s1;
                if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt <= '0;
                    r_db  <= r_s2;
                end else begin
                    r_cnt <= r_cnt + c_DB_W'(1);
                end
            end
        end

        assign w_press[i] = r_s2 && !r_db && (r_cnt == c_DB_LAST);
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_tick = r_running && (r_ps == c_PS_LAST);
    // A toggle press landing on a tick swallows that tick.
    assign w_req  = r_running ? (w_tick && !w_press[1]) : w_press[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= WIDTH'(1);
            r_bc      <= 1'b0;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
            r_adv     <= 1'b0;
            r_ps      <= '0;
        end else if (clr) begin
            r_a   <= '0;
            r_b   <= WIDTH'(1);
            r_bc  <= 1'b0;
            r_ovf <= 1'b0;
            r_adv <= 1'b0;
            r_ps  <= '0;
        end else begin
            r_adv <= w_req;
            if (w_press[1]) begin
                r_running <= !r_running;
                r_ps      <= '0;
            end else if (r_running) begin
                r_ps <= w_tick ? '0 : r_ps + c_PS_W'(1);
            end else begin
                r_ps <= '0;
            end

            if (w_req) begin
                if (!r_bc) begin
                    r_a         <= r_b;
                    {r_bc, r_b} <= w_sum;
                end else begin
                    // Carry pending: the next term does not fit in WIDTH bits.
                    r_ovf <= 1'b1;
                    if (halt_on_ovf) begin
                        r_running <= 1'b0;
                    end else begin
                        r_a  <= '0;
                        r_b  <= WIDTH'(1);
                        r_bc <= 1'b0;
                    end
                end
            end
        end
    end

    assign value   = r_a;
    assign running = r_running;
    assign ovf     = r_ovf;
    assign adv     = r_adv;

    logic [c_PAD_W-1:0] w_pad;
    logic [LED_W-1:0]   w_slice [c_NSLICE];

    if (c_PAD_W > WIDTH) begin : g_pad_ext
        assign w_pad = {{(c_PAD_W - WIDTH){1'b0}}, r_a};
    end else if (c_PAD_W == WIDTH) begin : g_pad_eq
        assign w_pad = r_a;
    end else begin : g_pad_trunc
        assign w_pad = r_a[c_PAD_W-1:0];
    end

    for (genvar k = 0; k < c_NSLICE; k++) begin : g_slice
        assign w_slice[k] = w_pad[k*LED_W +: LED_W];
    end

    assign led = w_slice[led_sel];

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_gen
// Brief    : Directed self-checking bench for fib_seq_gen (WIDTH=8, LED_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_seq_gen;

    localparam int WIDTH    = 8;
    localparam int LED_W    = 4;
    localparam int SEL_W    = 2;
    localparam int PRESCALE = 4;
    localparam int DEBOUNCE = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       buttons;
    logic             clr;
    logic             halt_on_ovf;
    logic [SEL_W-1:0] led_sel;
    logic [LED_W-1:0] led;
    logic [WIDTH-1:0] value;
    logic             running;
    logic             ovf;
    logic             adv;

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0] fib13 [13] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                               8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};
    logic [7:0] run1 [6] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
    logic [7:0] run2 [8] = '{8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd0};
    logic [3:0] led233 [4] = '{4'h9, 4'hE, 4'h0, 4'h0};

    fib_seq_gen #(
        .WIDTH(WIDTH), .LED_W(LED_W), .PRESCALE(PRESCALE),
        .DEBOUNCE(DEBOUNCE), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .clr(clr),
        .halt_on_ovf(halt_on_ovf), .led_sel(led_sel), .led(led),
        .value(value), .running(running), .ovf(ovf), .adv(adv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clean press in STEP mode: adv must appear exactly 5 cycles after the edge.
    task automatic step_press(input int idx, input logic [7:0] exp_v, input string tag);
        @(negedge clk);
        buttons[idx] = 1'b1;
        repeat (4) @(negedge clk);
        chk({tag, "_adv_early"}, 32'(adv), 32'd0);
        @(negedge clk);
        chk({tag, "_adv"}, 32'(adv), 32'd1);
        chk({tag, "_val"}, 32'(value), 32'(exp_v));
        @(negedge clk);
        chk({tag, "_adv_pulse"}, 32'(adv), 32'd0);
        buttons[idx] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic clear_seq(input string tag);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk({tag, "_val"}, 32'(value), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        buttons     = 2'b00;
        clr         = 1'b0;
        halt_on_ovf = 1'b0;
        led_sel     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_adv", 32'(adv), 32'd0);
            led_sel = 2'(i);
            #1 chk("rst_led", 32'(led), 32'd0);
        end
        chk("rst_val", 32'(value), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // 13 steps with wrap on overflow
        for (int i = 0; i < 13; i++) step_press(0, fib13[i], "step");
        for (int s = 0; s < 4; s++) begin
            led_sel = 2'(s);
            #1 chk("led233", 32'(led), 32'(led233[s]));
        end
        chk("ovf_before", 32'(ovf), 32'd0);
        step_press(0, 8'd0, "wrap");
        chk("wrap_ovf", 32'(ovf), 32'd1);
        step_press(0, 8'd1, "wrap1");
        step_press(0, 8'd1, "wrap2");
        step_press(0, 8'd2, "wrap3");
        chk("wrap_ovf_sticky", 32'(ovf), 32'd1);

        // Halt on overflow
        clear_seq("clr_step");
        for (int i = 0; i < 13; i++) step_press(0, fib13[i], "step_b");
        halt_on_ovf = 1'b1;
        step_press(0, 8'd233, "halt");
        chk("halt_ovf", 32'(ovf), 32'd1);
        chk("halt_run", 32'(running), 32'd0);
        step_press(0, 8'd233, "halt2");

        // Glitch rejection in STEP mode
        clear_seq("clr_glitch");
        halt_on_ovf = 1'b0;
        @(negedge clk);
        buttons[0] = 1'b1;
        repeat (2) @(negedge clk);
        buttons[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("glitch_adv", 32'(adv), 32'd0);
        end
        chk("glitch_val", 32'(value), 32'd0);

        // Enter RUN; step presses ignored; toggle lands on a tick
        @(negedge clk);
        buttons[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("tog_run", 32'(running), 32'd1);
        chk("tog_adv", 32'(adv), 32'd0);
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            if (k == 27) begin
                chk("tog_tick_adv", 32'(adv), 32'd0);
                chk("tog_tick_run", 32'(running), 32'd0);
                chk("tog_tick_val", 32'(value), 32'd8);
            end else begin
                chk("run_adv", 32'(adv), 32'(k % 4 == 3));
                if (k % 4 == 3) chk("run_val", 32'(value), 32'(run1[k/4]));
            end
            if (k == 1)  buttons[1] = 1'b0;
            if (k == 2)  buttons[0] = 1'b1;
            if (k == 12) buttons[0] = 1'b0;
            if (k == 22) buttons[1] = 1'b1;
        end
        buttons[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stopped_adv", 32'(adv), 32'd0);
        end
        chk("stopped_val", 32'(value), 32'd8);

        // Resume RUN to overflow, then clr mid-count
        @(negedge clk);
        buttons[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("tog2_run", 32'(running), 32'd1);
        buttons[1] = 1'b0;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            chk("run2_adv", 32'(adv), 32'(j % 4 == 3));
            if (j % 4 == 3) chk("run2_val", 32'(value), 32'(run2[j/4]));
        end
        chk("run2_ovf", 32'(ovf), 32'd1);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_run_val", 32'(value), 32'd0);
        chk("clr_run_ovf", 32'(ovf), 32'd0);
        chk("clr_run_run", 32'(running), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_run_wait", 32'(adv), 32'd0);
        end
        @(negedge clk);
        chk("clr_run_adv", 32'(adv), 32'd1);
        chk("clr_run_next", 32'(value), 32'd1);

        // Asynchronous reset mid-count
        @(negedge clk);
        led_sel = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_val", 32'(value), 32'd0);
        chk("arst_run", 32'(running), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_adv", 32'(adv), 32'd0);
        chk("arst_led", 32'(led), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
